// File: rtl/bram_test_pkg.sv
// Shared definitions for the BRAM pattern tester: FSM encoding, pattern modes, LFSR constants.
// Pure definitions; no latency or flow control of its own.
package bram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR    = 2'd0,
    MODE_INV     = 2'd1,
    MODE_LFSR    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [15:0] pattern_word(input mode_t mode, input logic [15:0] addr,
                                               input logic [15:0] lfsr);
    case (mode)
      MODE_ADDR: return addr;
      MODE_INV:  return ~addr;
      MODE_LFSR: return lfsr;
      default:   return addr[0] ? 16'hAAAA : 16'h5555;
    endcase
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM, one clock, one write and one registered read port.
// Latency: read data valid 1 cycle after rd_en; no backpressure, always accepts.
module bram_sdp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bram_pattern_tester.sv
// Memory self-test: writes a selectable pattern over DEPTH words, reads it back and counts mismatches.
// Latency: DEPTH write + DEPTH read + 1 drain cycle from accepted start to done; no backpressure.
module bram_pattern_tester
  import bram_test_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1024,
  parameter int ERR_W  = 16
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic              locked,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              inject_en,
  input  logic [ADDR_W-1:0] inject_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic              inject_q;
  logic [ADDR_W-1:0] inject_addr_q;
  logic [15:0]       lfsr_q;
  logic              run, kill, start_go;
  logic              wr_en, rd_en, rd_vld_q, mismatch;
  logic [DATA_W-1:0] wr_pat, rd_pat, exp_q, ram_q;
  logic [ADDR_W-1:0] cmp_addr_q;

  assign run      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  // Losing the clock-valid qualifier mid-run is handled exactly like an abort.
  assign kill     = abort || (run && !locked);
  assign start_go = start && locked && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign busy     = run;
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_go) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (wr_addr == LAST_ADDR) state_d = ST_READ;
      end
      ST_READ: begin
        rd_en = 1'b1;
        if (rd_addr == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start_go) state_d = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_IDLE;
  end

  assign wr_pat = DATA_W'(pattern_word(mode_q, 16'(wr_addr), lfsr_q));
  assign rd_pat = DATA_W'(pattern_word(mode_q, 16'(rd_addr), lfsr_q));

  // Injected fault corrupts only the stored word; the read-side expectation stays clean.
  assign wr_data  = wr_en ? (wr_pat ^ DATA_W'(inject_q && (wr_addr == inject_addr_q))) : '0;
  assign rd_data  = rd_vld_q ? ram_q : '0;
  assign mismatch = rd_vld_q && (ram_q != exp_q);

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      wr_addr        <= '0;
      rd_addr        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      lfsr_q         <= LFSR_SEED;
      mode_q         <= MODE_ADDR;
      inject_q       <= 1'b0;
      inject_addr_q  <= '0;
      rd_vld_q       <= 1'b0;
      exp_q          <= '0;
      cmp_addr_q     <= '0;
    end else begin
      rd_vld_q <= rd_en && !kill;
      if (rd_en) begin
        exp_q      <= rd_pat;
        cmp_addr_q <= rd_addr;
      end
      if (start_go) begin
        wr_addr        <= '0;
        rd_addr        <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
        lfsr_q         <= LFSR_SEED;
        mode_q         <= mode_t'(mode);
        inject_q       <= inject_en;
        inject_addr_q  <= inject_addr;
      end else if (kill) begin
        wr_addr <= '0;
        rd_addr <= '0;
        lfsr_q  <= LFSR_SEED;
      end else begin
        // Counters park on the last address so they never wrap when DEPTH < 2**ADDR_W.
        if (wr_en) begin
          if (wr_addr == LAST_ADDR) begin
            lfsr_q <= LFSR_SEED;
          end else begin
            lfsr_q  <= lfsr_step(lfsr_q);
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        if (rd_en) begin
          lfsr_q <= lfsr_step(lfsr_q);
          if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + ADDR_W'(1);
        end
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
          if (err_count == '0) first_err_addr <= cmp_addr_q;
        end
      end
    end
  end

  bram_sdp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk_in1),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_bram_pattern_tester.sv
// Bench for bram_pattern_tester: scoreboard of written/read words plus status checks per scenario.
module tb_bram_pattern_tester;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 16;
  localparam int ERR_W  = 16;

  logic              clk = 1'b0;
  logic              reset, locked, start, abort, inject_en;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] inject_addr;
  logic [ADDR_W-1:0] wr_addr, rd_addr, first_err_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_count;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] wq[$];
  logic [DATA_W-1:0] rq[$];
  logic [DATA_W-1:0] first_wr;

  always #5 clk = ~clk;

  bram_pattern_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(ERR_W)
  ) dut (
    .clk_in1(clk), .reset(reset), .locked(locked), .start(start), .abort(abort),
    .mode(mode), .inject_en(inject_en), .inject_addr(inject_addr),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  function automatic logic [15:0] m_lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] m_word(input logic [1:0] m, input int a, input logic [15:0] lf);
    case (m)
      2'd0:    return DATA_W'(a);
      2'd1:    return ~DATA_W'(a);
      2'd2:    return lf[DATA_W-1:0];
      default: return a[0] ? 10'h2AA : 10'h155;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s busy got %b want 0", tag, busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s done got %b want 0", tag, done); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL %s pass got %b want 0", tag, pass); end
    tests++; if (wr_addr !== '0) begin fails++; $display("FAIL %s wr_addr got %0d want 0", tag, wr_addr); end
    tests++; if (wr_data !== '0) begin fails++; $display("FAIL %s wr_data got %h want 0", tag, wr_data); end
    tests++; if (rd_addr !== '0) begin fails++; $display("FAIL %s rd_addr got %0d want 0", tag, rd_addr); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL %s rd_data got %h want 0", tag, rd_data); end
  endtask

  // Full run: pushes the expected stream at start, then pops it as the DUT writes and reads.
  task automatic run_test(input logic [1:0] m, input logic ie, input logic [ADDR_W-1:0] ia);
    logic [15:0]       lf;
    logic [DATA_W-1:0] w;
    int                exp_err;
    lf = 16'hACE1;
    wq.delete();
    rq.delete();
    step();
    start = 1'b1; mode = m; inject_en = ie; inject_addr = ia; locked = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      w  = m_word(m, i, lf);
      lf = m_lfsr_next(lf);
      if (ie && (i == int'(ia))) w = w ^ 10'h001;
      wq.push_back(w);
      rq.push_back(w);
    end
    exp_err = ie ? 1 : 0;
    step();
    start = 1'b0; inject_en = 1'b0; mode = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w = wq.pop_front();
      if (i == 0) first_wr = wr_data;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy[%0d] got %b want 1", i, busy); end
      tests++; if (wr_addr !== ADDR_W'(i)) begin fails++; $display("FAIL wr_addr[%0d] got %0d want %0d", i, wr_addr, i); end
      tests++; if (wr_data !== w) begin fails++; $display("FAIL wr_data[%0d] got %h want %h", i, wr_data, w); end
      step();
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests++; if (rd_addr !== ADDR_W'(i)) begin fails++; $display("FAIL rd_addr[%0d] got %0d want %0d", i, rd_addr, i); end
      if (i > 0) begin
        w = rq.pop_front();
        tests++; if (rd_data !== w) begin fails++; $display("FAIL rd_data[%0d] got %h want %h", i - 1, rd_data, w); end
      end
      step();
    end
    w = rq.pop_front();
    tests++; if (rd_data !== w) begin fails++; $display("FAIL rd_data_last got %h want %h", rd_data, w); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL drain_busy got %b want 1", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL drain_done got %b want 0", done); end
    step();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL done got %b want 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_busy got %b want 0", busy); end
    tests++; if (err_count !== ERR_W'(exp_err)) begin fails++; $display("FAIL err_count got %0d want %0d", err_count, exp_err); end
    tests++; if (pass !== (exp_err == 0)) begin fails++; $display("FAIL pass got %b want %b", pass, exp_err == 0); end
    tests++; if (first_err_addr !== (ie ? ia : '0)) begin fails++; $display("FAIL first_err_addr got %0d want %0d", first_err_addr, ie ? ia : '0); end
    tests++; if (rd_addr !== ADDR_W'(DEPTH - 1)) begin fails++; $display("FAIL rd_addr_park got %0d want %0d", rd_addr, DEPTH - 1); end
  endtask

  task automatic test_reset();
    reset = 1'b1; locked = 1'b0; start = 1'b0; abort = 1'b0;
    mode = 2'd0; inject_en = 1'b0; inject_addr = '0;
    step();
    chk_idle_zero("reset");
    tests++; if (err_count !== '0) begin fails++; $display("FAIL reset_err got %0d want 0", err_count); end
    tests++; if (first_err_addr !== '0) begin fails++; $display("FAIL reset_first got %0d want 0", first_err_addr); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_mode_addr();
    run_test(2'd0, 1'b0, '0);
  endtask

  task automatic test_lfsr();
    run_test(2'd2, 1'b0, '0);
    tests++; if (first_wr !== 10'h0E1) begin fails++; $display("FAIL lfsr_first got %h want 0e1", first_wr); end
  endtask

  task automatic test_inject();
    run_test(2'd1, 1'b1, 4'd5);
  endtask

  task automatic test_abort_retain();
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", done); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL abort_pass got %b want 0", pass); end
    tests++; if (err_count !== ERR_W'(1)) begin fails++; $display("FAIL abort_err_keep got %0d want 1", err_count); end
  endtask

  task automatic test_locked_low();
    locked = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nolock_busy[%0d] got %b want 0", i, busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL nolock_done[%0d] got %b want 0", i, done); end
      step();
    end
    locked = 1'b1;
  endtask

  task automatic test_abort_read();
    start = 1'b1; mode = 2'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < DEPTH + 7; i++) step();
    tests++; if (rd_addr !== 4'd7) begin fails++; $display("FAIL abort_at got %0d want 7", rd_addr); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_rd_done got %b want 0", done); end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_stay got %b want 0", busy); end
    run_test(2'd0, 1'b0, '0);
  endtask

  task automatic test_locked_drop();
    start = 1'b1; mode = 2'd3;
    step();
    start = 1'b0;
    step(); step();
    locked = 1'b0;
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lockdrop_busy got %b want 0", busy); end
    locked = 1'b1;
    run_test(2'd3, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; mode = 2'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pre_reset_busy got %b want 1", busy); end
    reset = 1'b1;
    #1;
    chk_idle_zero("mid_reset");
    tests++; if (err_count !== '0) begin fails++; $display("FAIL mid_reset_err got %0d want 0", err_count); end
    #2;
    reset = 1'b0;
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got %b want 0", busy); end
    run_test(2'd2, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_mode_addr();
    test_lfsr();
    test_inject();
    test_abort_retain();
    test_locked_low();
    test_abort_read();
    test_locked_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_pattern_tester.md
BRAM_PATTERN_TESTER -- requirements
Module: bram_pattern_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the RAM address width.
REQ-002 SHALL have parameter DATA_W, default 10, the RAM data width; legal range 1..16.
REQ-003 SHALL have parameter DEPTH, default 1024, the number of words tested; legal range 2..2^ADDR_W.
REQ-004 SHALL have parameter ERR_W, default 16, the error counter width.
REQ-005 SHALL have port clk_in1, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port locked, input, 1 bit: upstream clock-valid qualifier; start is ignored while it is low.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to begin a test run.
REQ-009 SHALL have port abort, input, 1 bit: synchronous return to IDLE.
REQ-010 SHALL have port mode, input, 2 bits: pattern select, sampled at start.
REQ-011 SHALL have port inject_en, input, 1 bit, and port inject_addr, input, ADDR_W bits: fault injection controls, sampled at start.
REQ-012 SHALL have outputs wr_addr (ADDR_W bits), wr_data (DATA_W bits), rd_addr (ADDR_W bits) and rd_data (DATA_W bits): the live RAM port values.
REQ-013 SHALL have outputs busy, done and pass, 1 bit each: run status.
REQ-014 SHALL have outputs err_count (ERR_W bits) and first_err_addr (ADDR_W bits): the mismatch summary.

Function
REQ-015 SHALL implement the FSM states IDLE, WRITE, READ, DRAIN and DONE.
REQ-016 SHALL move from IDLE or DONE to WRITE on start=1 with locked=1; start SHALL be ignored in WRITE, READ and DRAIN.
REQ-017 In WRITE, SHALL write one word per cycle at wr_addr = 0..DEPTH-1 with wr_en high, then go to READ after address DEPTH-1.
REQ-018 In READ, SHALL issue one read per cycle at rd_addr = 0..DEPTH-1, then go to DRAIN for exactly 1 cycle, then to DONE.
REQ-019 SHALL give the RAM a read latency of 1 cycle; rd_data for rd_addr issued in cycle N SHALL be compared in cycle N+1 against a 1-cycle-delayed expected value.
REQ-020 SHALL generate patterns by mode: 0 = address zero-extended or truncated to DATA_W; 1 = bitwise inverse of mode 0; 2 = 16-bit Galois LFSR (taps 16,14,13,11, seed 0xACE1) low DATA_W bits, stepping once per word and reseeded at the start of both WRITE and READ; 3 = alternating 0101... / 1010... by address LSB.
REQ-021 With inject_en=1, SHALL flip bit 0 of the word written at inject_addr; the expected value SHALL NOT be flipped.
REQ-022 On each mismatch, SHALL increment err_count, saturating at 2^ERR_W-1.
REQ-023 On the first mismatch of a run, SHALL capture its address into first_err_addr.
REQ-024 SHALL hold busy=1 in WRITE, READ and DRAIN.
REQ-025 SHALL hold done=1 in DONE, with pass = (err_count==0), until the next accepted start or abort.
REQ-026 An accepted start SHALL clear err_count, first_err_addr, done and pass in the same edge.
REQ-027 abort=1 in any state SHALL force IDLE next cycle with done=0 and pass=0; err_count SHALL be retained; abort SHALL take priority over a simultaneous start.
REQ-028 If locked falls mid-run, SHALL treat it as abort.
REQ-029 When DEPTH < 2^ADDR_W, addresses SHALL stop at DEPTH-1 and SHALL never wrap past it.

Reset
REQ-030 On reset, SHALL enter IDLE.
REQ-031 On reset, all outputs SHALL be 0, including wr_addr, rd_addr, wr_data, rd_data, err_count and first_err_addr.
REQ-032 On reset, the LFSR SHALL return to 0xACE1.
REQ-033 Reset asserted mid-run SHALL abandon the run immediately; RAM contents are undefined afterwards.

Structure
REQ-034 SHALL place the FSM state encoding, the mode codes, and the LFSR seed and taps in the shared package bram_test_pkg.
REQ-035 SHALL hold storage in the sub-module bram_sdp: simple dual-port, single clock, registered read, inferable as block RAM, parametrised by ADDR_W, DATA_W and DEPTH.

Verification
REQ-036 Bench SHALL cover: DEPTH=16, mode 0, start with locked=1 -> wr_data 0..15 written, done after 16+16+1 cycles, pass=1, err_count=0.
REQ-037 Bench SHALL cover: mode 2, DATA_W=10 -> first written word 0x0E1, pass=1.
REQ-038 Bench SHALL cover: mode 1, inject_en=1, inject_addr=5 -> err_count=1, first_err_addr=5, pass=0.
REQ-039 Bench SHALL cover: start while locked=0 -> state stays IDLE, busy=0.
REQ-040 Bench SHALL cover: abort at READ address 7 -> IDLE next cycle, done=0; a rerun then passes.
REQ-041 Bench SHALL cover: reset pulsed mid-WRITE -> all outputs 0 within the same cycle, IDLE.
